boot_copy_engine: RTL

//   Bus read initiator that copies a block of 32-bit words from a read-only

---
 rtl/boot_copy_engine.sv | 132 +++++++++++++
 1 files changed

// File: rtl/boot_copy_engine.sv
// boot_copy_engine
//   Boot-time bus initiator that copies a block of 32-bit words from the
//   system ROM (read-only responder) into RAM. It reads one word and then
//   writes it, so each word takes two cycles when the RAM does not stall.
//
// Ports
//   clk, reset      single clock, synchronous active-high reset
//   start           copy request, accepted only while idle
//   srcBase/dstBase byte base addresses; the low two bits are dropped
//   wordCount       number of words to copy (0 completes immediately)
//   busy            high while reading or writing
//   done            one-cycle completion pulse
//   srcAddress/srcRead/srcReadData             ROM read port
//   dstAddress/dstWriteData/dstWrite/dstWaitRequest   RAM write port
module boot_copy_engine #(
    parameter int ADDR_WIDTH = 28,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] srcBase,
    input  logic [ADDR_WIDTH-1:0] dstBase,
    input  logic [LEN_WIDTH-1:0]  wordCount,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] srcAddress,
    output logic                  srcRead,
    input  logic [DATA_WIDTH-1:0] srcReadData,
    output logic [ADDR_WIDTH-1:0] dstAddress,
    output logic [DATA_WIDTH-1:0] dstWriteData,
    output logic                  dstWrite,
    input  logic                  dstWaitRequest
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WRITE,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] srcBase_q, srcBase_d;
    logic [ADDR_WIDTH-1:0] dstBase_q, dstBase_d;
    logic [LEN_WIDTH-1:0]  count_q, count_d;
    logic [LEN_WIDTH-1:0]  index_q, index_d;
    logic [DATA_WIDTH-1:0] buffer_q, buffer_d;

    // Byte offset of the current word; additions wrap modulo 2^ADDR_WIDTH.
    logic [ADDR_WIDTH-1:0] wordOffset;
    assign wordOffset = ADDR_WIDTH'({index_q, 2'b00});

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            srcBase_q <= '0;
            dstBase_q <= '0;
            count_q   <= '0;
            index_q   <= '0;
            buffer_q  <= '0;
        end else begin
            state_q   <= state_d;
            srcBase_q <= srcBase_d;
            dstBase_q <= dstBase_d;
            count_q   <= count_d;
            index_q   <= index_d;
            buffer_q  <= buffer_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        srcBase_d = srcBase_q;
        dstBase_d = dstBase_q;
        count_d   = count_q;
        index_d   = index_q;
        buffer_d  = buffer_q;

        busy         = 1'b0;
        done         = 1'b0;
        srcRead      = 1'b0;
        srcAddress   = '0;
        dstWrite     = 1'b0;
        dstAddress   = '0;
        dstWriteData = '0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    srcBase_d = srcBase & WORD_MASK;
                    dstBase_d = dstBase & WORD_MASK;
                    count_d   = wordCount;
                    index_d   = '0;
                    state_d   = (wordCount == '0) ? DONE : READ;
                end
            end
            READ: begin
                busy       = 1'b1;
                srcRead    = 1'b1;
                srcAddress = srcBase_q + wordOffset;
                buffer_d   = srcReadData;
                state_d    = WRITE;
            end
            WRITE: begin
                busy         = 1'b1;
                dstWrite     = 1'b1;
                dstAddress   = dstBase_q + wordOffset;
                dstWriteData = buffer_q;
                if (!dstWaitRequest) begin
                    // Compare against count-1 so the last index never has to
                    // be incremented; a full-scale count cannot overflow.
                    if (index_q == count_q - LEN_WIDTH'(1)) begin
                        state_d = DONE;
                    end else begin
                        index_d = index_q + LEN_WIDTH'(1);
                        state_d = READ;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
